// File: rtl/snake_pkg.sv
// ============================================================================
// Module   : snake_pkg
// Purpose  : Shared encodings, grid defaults and direction helpers for the
//            snake game controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_UP    = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  localparam int DEFAULT_GRID_W = 32;
  localparam int DEFAULT_GRID_H = 24;
  localparam int CELL_PX        = 20;

  // Opposite directions differ only in the upper encoding bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

`default_nettype wire

// File: rtl/snake_game_ctrl_if.sv
// ============================================================================
// Module   : snake_game_ctrl_if
// Purpose  : Player inputs and game-state outputs of the snake controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface snake_game_ctrl_if #(
  parameter int SCORE_W = 16
);
  logic [3:0]         KEY;
  logic               start;
  logic               move_clock;
  logic [4:0]         head_x;
  logic [4:0]         head_y;
  logic [1:0]         dir;
  logic               step;
  logic [1:0]         state;
  logic               game_over;
  logic [SCORE_W-1:0] score;

  modport master (
    input  KEY, start, move_clock,
    output head_x, head_y, dir, step, state, game_over, score
  );

  modport slave (
    output KEY, start, move_clock,
    input  head_x, head_y, dir, step, state, game_over, score
  );
endinterface

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module   : sync_edge
// Purpose  : Two-flop synchronizer with registered rise/fall pulse outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_async,
  output logic      o_level,
  output logic      o_rise,
  output logic      o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/snake_game_ctrl.sv
// ============================================================================
// Module   : snake_game_ctrl
// Purpose  : Snake game sequencer: state machine, direction and head position.
//            Define SNAKE_WRAP_EN to wrap at the border instead of dying.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W  = DEFAULT_GRID_W,
  parameter int GRID_H  = DEFAULT_GRID_H,
  parameter int START_X = 16,
  parameter int START_Y = 12,
  parameter int SCORE_W = 16
) (
  input wire logic         VGA_CLK,
  input wire logic         reset,
  snake_game_ctrl_if.master bus
);

  localparam logic [4:0]         X_MAX     = 5'(GRID_W - 1);
  localparam logic [4:0]         Y_MAX     = 5'(GRID_H - 1);
  localparam logic [4:0]         X0        = 5'(START_X);
  localparam logic [4:0]         Y0        = 5'(START_Y);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  logic [3:0] w_key_level, w_key_rise, w_key_fall;
  logic       w_start_level, w_start_rise, w_start_fall;
  logic       w_move_level, w_tick, w_move_fall;

  for (genvar i = 0; i < 4; i++) begin : g_key_sync
    sync_edge #(.RST_VAL(1'b1)) u_key (
      .clk     (VGA_CLK),
      .rst_n   (reset),
      .i_async (bus.KEY[i]),
      .o_level (w_key_level[i]),
      .o_rise  (w_key_rise[i]),
      .o_fall  (w_key_fall[i])
    );
  end

  sync_edge #(.RST_VAL(1'b0)) u_start (
    .clk     (VGA_CLK),
    .rst_n   (reset),
    .i_async (bus.start),
    .o_level (w_start_level),
    .o_rise  (w_start_rise),
    .o_fall  (w_start_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_move (
    .clk     (VGA_CLK),
    .rst_n   (reset),
    .i_async (bus.move_clock),
    .o_level (w_move_level),
    .o_rise  (w_tick),
    .o_fall  (w_move_fall)
  );

  // Synchronizer outputs this controller has no use for.
  logic w_unused_sync;
  assign w_unused_sync = ^{w_key_level, w_key_rise, w_start_rise, w_start_fall,
                           w_move_level, w_move_fall};

  state_t             r_state;
  dir_t               r_dir;
  dir_t               r_pend;
  logic               r_pend_vld;
  logic [4:0]         r_head_x;
  logic [4:0]         r_head_y;
  logic               r_step;
  logic               r_game_over;
  logic [SCORE_W-1:0] r_score;

  logic       w_press;
  dir_t       w_press_dir;
  dir_t       w_new_dir;
  logic [4:0] w_nx, w_ny;
  logic [4:0] w_dst_x, w_dst_y;
  logic       w_hit;

  always_comb begin
    w_press     = 1'b1;
    w_press_dir = DIR_RIGHT;
    if (w_key_fall[0])      w_press_dir = DIR_RIGHT;
    else if (w_key_fall[1]) w_press_dir = DIR_DOWN;
    else if (w_key_fall[2]) w_press_dir = DIR_LEFT;
    else if (w_key_fall[3]) w_press_dir = DIR_UP;
    else                    w_press     = 1'b0;
  end

  always_comb begin
    w_new_dir = r_pend_vld ? r_pend : r_dir;
    w_nx      = r_head_x;
    w_ny      = r_head_y;
    case (w_new_dir)
      DIR_RIGHT: w_nx = r_head_x + 5'd1;
      DIR_DOWN:  w_ny = r_head_y + 5'd1;
      DIR_LEFT:  w_nx = r_head_x - 5'd1;
      default:   w_ny = r_head_y - 5'd1;
    endcase
  end

`ifdef SNAKE_WRAP_EN
  always_comb begin
    w_dst_x = w_nx;
    w_dst_y = w_ny;
    w_hit   = 1'b0;
    if (w_nx == 5'd0)       w_dst_x = X_MAX - 5'd1;
    else if (w_nx == X_MAX) w_dst_x = 5'd1;
    if (w_ny == 5'd0)       w_dst_y = Y_MAX - 5'd1;
    else if (w_ny == Y_MAX) w_dst_y = 5'd1;
  end
`else
  assign w_dst_x = w_nx;
  assign w_dst_y = w_ny;
  assign w_hit   = (w_nx == 5'd0) || (w_nx == X_MAX) ||
                   (w_ny == 5'd0) || (w_ny == Y_MAX);
`endif

  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_RIGHT;
      r_pend      <= DIR_RIGHT;
      r_pend_vld  <= 1'b0;
      r_head_x    <= X0;
      r_head_y    <= Y0;
      r_step      <= 1'b0;
      r_game_over <= 1'b0;
      r_score     <= '0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_game_over <= 1'b0;
          if (w_start_level) begin
            r_state    <= ST_PLAY;
            r_head_x   <= X0;
            r_head_y   <= Y0;
            r_dir      <= DIR_RIGHT;
            r_pend     <= DIR_RIGHT;
            r_pend_vld <= 1'b0;
            r_score    <= '0;
          end
        end
        ST_PLAY: begin
          if (!w_start_level) begin
            r_state <= ST_IDLE;
          end else begin
            if (w_tick) begin
              r_dir      <= w_new_dir;
              r_pend_vld <= 1'b0;
              if (w_hit) begin
                r_state     <= ST_DEAD;
                r_game_over <= 1'b1;
              end else begin
                r_head_x <= w_dst_x;
                r_head_y <= w_dst_y;
                r_step   <= 1'b1;
                if (r_score != '1) r_score <= r_score + SCORE_ONE;
              end
            end
            // Placed after the tick so a same-cycle press survives for the next tick.
            if (w_press && !is_reverse(w_press_dir, r_dir)) begin
              r_pend     <= w_press_dir;
              r_pend_vld <= 1'b1;
            end
          end
        end
        ST_DEAD: begin
          if (!w_start_level) begin
            r_state     <= ST_IDLE;
            r_game_over <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.head_x    = r_head_x;
  assign bus.head_y    = r_head_y;
  assign bus.dir       = r_dir;
  assign bus.step      = r_step;
  assign bus.state     = r_state;
  assign bus.game_over = r_game_over;
  assign bus.score     = r_score;

endmodule

`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
// ============================================================================
// Module   : tb_snake_game_ctrl
// Purpose  : Directed vector bench for snake_game_ctrl (wrap or collide build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snake_game_ctrl;

  logic clk;
  logic reset_n;

  snake_game_ctrl_if #(.SCORE_W(16)) bus ();

  snake_game_ctrl #(
    .GRID_W  (32),
    .GRID_H  (24),
    .START_X (16),
    .START_Y (12),
    .SCORE_W (16)
  ) dut (
    .VGA_CLK (clk),
    .reset   (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int step_cnt = 0;

  always @(negedge clk) if (bus.step === 1'b1) step_cnt <= step_cnt + 1;

  typedef struct {
    logic       start;
    logic [3:0] press_a;
    logic [3:0] press_b;
    int         ticks;
    int         exp_state;
    int         exp_x;
    int         exp_y;
    int         exp_dir;
    int         exp_steps;
    int         exp_score;
    int         exp_go;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask);
    bus.KEY = ~mask;
    cycles(5);
    bus.KEY = 4'hF;
    cycles(5);
  endtask

  task automatic tick();
    bus.move_clock = 1'b1;
    cycles(6);
    bus.move_clock = 1'b0;
    cycles(4);
  endtask

  task automatic check_all(input string tag, input int st, input int x, input int y,
                           input int d, input int sc, input int go);
    check({tag, " state"}, 32'(bus.state), 32'(st));
    check({tag, " head_x"}, 32'(bus.head_x), 32'(x));
    check({tag, " head_y"}, 32'(bus.head_y), 32'(y));
    check({tag, " dir"}, 32'(bus.dir), 32'(d));
    check({tag, " score"}, 32'(bus.score), 32'(sc));
    check({tag, " game_over"}, 32'(bus.game_over), 32'(go));
  endtask

  initial begin
    int base;
    int first_k;
    int seen;

    //           start press_a press_b ticks st  x   y  dir stp score go
    vecs[0]  = '{1'b0, 4'h0, 4'h0, 0, 0, 16, 12, 0, 0, 0,  0};
    vecs[1]  = '{1'b1, 4'h0, 4'h0, 0, 1, 16, 12, 0, 0, 0,  0};
    vecs[2]  = '{1'b1, 4'h0, 4'h0, 3, 1, 19, 12, 0, 3, 3,  0};
    vecs[3]  = '{1'b1, 4'h4, 4'h0, 1, 1, 20, 12, 0, 1, 4,  0};
    vecs[4]  = '{1'b1, 4'h8, 4'h2, 1, 1, 20, 13, 1, 1, 5,  0};
    vecs[5]  = '{1'b1, 4'h8, 4'h0, 1, 1, 20, 14, 1, 1, 6,  0};
    vecs[6]  = '{1'b1, 4'h1, 4'h0, 1, 1, 21, 14, 0, 1, 7,  0};
    vecs[7]  = '{1'b1, 4'h0, 4'h0, 8, 1, 29, 14, 0, 8, 15, 0};
    vecs[8]  = '{1'b1, 4'h0, 4'h0, 1, 1, 30, 14, 0, 1, 16, 0};
`ifdef SNAKE_WRAP_EN
    vecs[9]  = '{1'b1, 4'h0, 4'h0, 1, 1, 1,  14, 0, 1, 17, 0};
    vecs[10] = '{1'b0, 4'h0, 4'h0, 0, 0, 1,  14, 0, 0, 17, 0};
    vecs[11] = '{1'b0, 4'h2, 4'h0, 1, 0, 1,  14, 0, 0, 17, 0};
`else
    vecs[9]  = '{1'b1, 4'h0, 4'h0, 1, 2, 30, 14, 0, 0, 16, 1};
    vecs[10] = '{1'b0, 4'h0, 4'h0, 0, 0, 30, 14, 0, 0, 16, 0};
    vecs[11] = '{1'b0, 4'h2, 4'h0, 1, 0, 30, 14, 0, 0, 16, 0};
`endif
    vecs[12] = '{1'b1, 4'h0, 4'h0, 1, 1, 17, 12, 0, 1, 1,  0};
    vecs[13] = '{1'b1, 4'h6, 4'h0, 1, 1, 17, 13, 1, 1, 2,  0};

    reset_n        = 1'b0;
    bus.KEY        = 4'hF;
    bus.start      = 1'b0;
    bus.move_clock = 1'b0;
    cycles(4);
    check("reset step", 32'(bus.step), 32'd0);
    reset_n = 1'b1;
    cycles(2);

    for (int i = 0; i < 14; i++) begin
      bus.start = vecs[i].start;
      cycles(4);
      if (vecs[i].press_a != 4'h0) press(vecs[i].press_a);
      if (vecs[i].press_b != 4'h0) press(vecs[i].press_b);
      base = step_cnt;
      for (int t = 0; t < vecs[i].ticks; t++) tick();
      check_all($sformatf("v%0d", i), vecs[i].exp_state, vecs[i].exp_x, vecs[i].exp_y,
                vecs[i].exp_dir, vecs[i].exp_score, vecs[i].exp_go);
      check($sformatf("v%0d steps", i), 32'(step_cnt - base), 32'(vecs[i].exp_steps));
    end

    // Step latency from the move_clock edge, and single-cycle width.
    first_k = 0;
    seen    = 0;
    bus.move_clock = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.step === 1'b1) begin
        seen++;
        if (first_k == 0) first_k = k;
      end
    end
    bus.move_clock = 1'b0;
    cycles(4);
    check("latency cycles", 32'(first_k), 32'd4);
    check("step width", 32'(seen), 32'd1);
    check("latency head_y", 32'(bus.head_y), 32'd14);

    // Tick and press in the same cycle: press waits for the next tick.
    bus.move_clock = 1'b1;
    bus.KEY        = 4'hE;
    cycles(6);
    bus.move_clock = 1'b0;
    bus.KEY        = 4'hF;
    cycles(4);
    check_all("same-cycle tick1", 1, 17, 15, 1, 4, 0);
    tick();
    check_all("same-cycle tick2", 1, 18, 15, 0, 5, 0);

    // Start falling in the same cycle as a tick: no step.
    base = step_cnt;
    bus.move_clock = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles(5);
    bus.move_clock = 1'b0;
    cycles(4);
    check_all("start-vs-tick", 0, 18, 15, 0, 5, 0);
    check("start-vs-tick steps", 32'(step_cnt - base), 32'd0);

    // Asynchronous reset in the middle of play.
    bus.start = 1'b1;
    cycles(4);
    tick();
    tick();
    check_all("pre-reset", 1, 18, 12, 0, 2, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async reset", 0, 16, 12, 0, 0, 0);
    check("async reset step", 32'(bus.step), 32'd0);
    cycles(2);
    reset_n = 1'b1;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
